nn_load_sequencer: RTL and testbench

NN_LOAD_SEQUENCER -- requirements
Module: nn_load_sequencer

---
 rtl/nn_seq_pkg.sv | 38 +++
 rtl/flex_counter.sv | 35 +++
 rtl/nn_load_sequencer.sv | 166 ++++++++++++++++
 tb/tb_nn_load_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// State encoding, default layer sizes and derived per-layer word/row constants
// shared by the NN load sequencer.
package nn_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StImage = 3'd1;
  localparam state_t StL1    = 3'd2;
  localparam state_t StL2    = 3'd3;
  localparam state_t StL3    = 3'd4;
  localparam state_t StFin   = 3'd5;

  localparam int unsigned DefImageSize   = 64;
  localparam int unsigned DefFirstLayer  = 16;
  localparam int unsigned DefSecondLayer = 8;
  localparam int unsigned DefThirdLayer  = 10;

  localparam int unsigned ImageWords = DefImageSize;
  localparam int unsigned L1Words    = DefImageSize * DefFirstLayer;
  localparam int unsigned L2Words    = DefFirstLayer * DefSecondLayer;
  localparam int unsigned L3Words    = DefSecondLayer * DefThirdLayer;
  localparam int unsigned TotalWords = ImageWords + L1Words + L2Words + L3Words;

  localparam int unsigned L1RowLen = DefImageSize;
  localparam int unsigned L2RowLen = DefFirstLayer;
  localparam int unsigned L3RowLen = DefSecondLayer;

  function automatic logic [1:0] layer_of(state_t s);
    case (s)
      StL1:    return 2'd1;
      StL2:    return 2'd2;
      StL3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping counter 0..rollover_val-1; rollover_flag marks the last position.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  assign rollover_flag = (count_q == rollover_val - 1'b1);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = rollover_flag ? '0 : count_q + 1'b1;
    end
  end

  // Reset is sampled synchronously to match the rest of the sequencer.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nn_load_sequencer.sv
// Streams the image then layer 1..3 coefficients from Avalon-MM memory.
// Optional SEQ_STALL_CNT_EN adds a saturating waitrequest stall counter output.
module nn_load_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE   = DefImageSize,
  parameter int unsigned FIRST_LAYER  = DefFirstLayer,
  parameter int unsigned SECOND_LAYER = DefSecondLayer,
  parameter int unsigned THIRD_LAYER  = DefThirdLayer
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        consumer_ready,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [15:0] avm_readdata,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        n_coef_image,
  output logic [6:0]  coef_select,
  output logic [1:0]  layer,
  output logic        busy,
  output logic        done
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  state_t      state_q, state_d, next_fetch;
  logic [31:0] addr_q;
  logic        pend_q;
  logic [15:0] word_cnt_q;
  logic [6:0]  neuron_q;
  logic [15:0] state_words, row_len;
  logic        fetch, accept, last_word, advance, row_flag, start_ok;
  logic [15:0] data_q;
  logic        valid_q, nci_q, done_q;
  logic [6:0]  coef_q;
  logic [1:0]  layer_q;

  always_comb begin
    state_words = 16'd1;
    row_len     = 16'd1;
    next_fetch  = StFin;
    case (state_q)
      StImage: begin
        state_words = 16'(IMAGE_SIZE);
        row_len     = 16'(IMAGE_SIZE);
        next_fetch  = StL1;
      end
      StL1: begin
        state_words = 16'(IMAGE_SIZE * FIRST_LAYER);
        row_len     = 16'(IMAGE_SIZE);
        next_fetch  = StL2;
      end
      StL2: begin
        state_words = 16'(FIRST_LAYER * SECOND_LAYER);
        row_len     = 16'(FIRST_LAYER);
        next_fetch  = StL3;
      end
      StL3: begin
        state_words = 16'(SECOND_LAYER * THIRD_LAYER);
        row_len     = 16'(SECOND_LAYER);
        next_fetch  = StFin;
      end
      default: ;
    endcase
  end

  assign fetch     = (state_q == StImage) || (state_q == StL1) ||
                     (state_q == StL2) || (state_q == StL3);
  // A stalled request stays up regardless of consumer_ready until accepted.
  assign avm_read  = fetch && (consumer_ready || pend_q);
  assign accept    = avm_read && !avm_waitrequest;
  assign last_word = (word_cnt_q == state_words - 16'd1);
  assign advance   = accept && last_word;
  assign start_ok  = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StImage;
      StFin:   state_d = StIdle;
      default: if (advance) state_d = next_fetch;
    endcase
  end

  flex_counter #(
    .NUM_CNT_BITS(16)
  ) u_row_cnt (
    .clk          (clk),
    .n_rst        (!rst),
    .clear        (advance || (state_q == StIdle)),
    .count_enable (accept),
    .rollover_val (row_len),
    .rollover_flag(row_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      word_cnt_q <= '0;
      neuron_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      nci_q      <= 1'b0;
      coef_q     <= '0;
      layer_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= avm_read && avm_waitrequest;
      if (start_ok) begin
        addr_q <= base_addr;
      end else if (accept) begin
        addr_q <= addr_q + 32'd1;
      end
      if (advance || (state_q == StIdle)) begin
        word_cnt_q <= '0;
        neuron_q   <= '0;
      end else if (accept) begin
        word_cnt_q <= word_cnt_q + 16'd1;
        if (row_flag && (state_q != StImage)) neuron_q <= neuron_q + 7'd1;
      end
      valid_q <= accept;
      // Sideband is captured with the word so it describes data_out exactly.
      if (accept) begin
        data_q  <= avm_readdata;
        coef_q  <= neuron_q;
        layer_q <= layer_of(state_q);
        nci_q   <= (state_q != StImage);
      end
      done_q <= (state_q == StFin);
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_q <= '0;
    end else if (avm_read && avm_waitrequest && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign avm_address  = addr_q;
  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign n_coef_image = nci_q;
  assign coef_select  = coef_q;
  assign layer        = layer_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Scoreboard bench: expected word stream queued at start, popped on data_valid.
module tb_nn_load_sequencer;

  localparam int Img = 64, N1 = 16, N2 = 8, N3 = 10;
  localparam int Total = Img + Img * N1 + N1 * N2 + N2 * N3;
  localparam int MDirect = 0, MStall = 1, MGap = 2, ML2Start = 3, MRand = 4, MRst = 5;

  typedef struct packed {
    logic       nci;
    logic [1:0] lyr;
    logic [6:0] coef;
    logic [15:0] data;
  } exp_t;

  logic        clk, rst, start, consumer_ready, avm_read, avm_waitrequest;
  logic [31:0] base_addr, avm_address;
  logic [15:0] avm_readdata, data_out;
  logic        data_valid, n_coef_image, busy, done;
  logic [6:0]  coef_select;
  logic [1:0]  layer;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  nn_load_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .consumer_ready (consumer_ready),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .n_coef_image   (n_coef_image),
    .coef_select    (coef_select),
    .layer          (layer),
    .busy           (busy),
    .done           (done)
`ifdef SEQ_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  function automatic logic [15:0] mem_word(logic [31:0] a);
    return a[15:0] ^ {a[23:16], a[31:24]} ^ 16'hA5C3;
  endfunction

  assign avm_readdata = mem_word(avm_address);

  // Reference: classify word i of the flat stream by layer and neuron row.
  function automatic exp_t ref_word(logic [31:0] base, int i);
    exp_t e;
    e.data = mem_word(base + 32'(i));
    if (i < Img) begin
      e.nci = 1'b0; e.lyr = 2'd0; e.coef = 7'd0;
    end else if (i < Img + Img * N1) begin
      e.nci = 1'b1; e.lyr = 2'd1; e.coef = 7'((i - Img) / Img);
    end else if (i < Img + Img * N1 + N1 * N2) begin
      e.nci = 1'b1; e.lyr = 2'd2; e.coef = 7'((i - Img - Img * N1) / N1);
    end else begin
      e.nci = 1'b1; e.lyr = 2'd3; e.coef = 7'((i - Img - Img * N1 - N1 * N2) / N2);
    end
    return e;
  endfunction

  int n_checks = 0, n_pass = 0, cyc = 0;
  int acc_cnt, valid_cnt, done_cnt, done_cyc, last_valid_cyc, a100a_cycles;
  logic [31:0] last_acc_addr, first_acc_addr, prev_addr;
  logic prev_hold = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("read_hold", {31'd0, avm_read}, 32'd1);
        check("addr_hold", avm_address, prev_addr);
      end else if (!consumer_ready) begin
        check("read_gated", {31'd0, avm_read}, 32'd0);
      end
      prev_hold = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      if (avm_read && avm_address == 32'h100A) a100a_cycles++;
      if (avm_read && !avm_waitrequest) begin
        if (acc_cnt == 0) first_acc_addr = avm_address;
        acc_cnt++;
        last_acc_addr = avm_address;
      end
      if (data_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, data_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("word_%0d", valid_cnt - 1),
                {6'd0, n_coef_image, layer, coef_select, data_out}, {6'd0, e});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_avm_read", {31'd0, avm_read}, 32'd0);
    check("rst_avm_address", avm_address, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_n_coef_image", {31'd0, n_coef_image}, 32'd0);
    check("rst_coef_select", {25'd0, coef_select}, 32'd0);
    check("rst_layer", {30'd0, layer}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef SEQ_STALL_CNT_EN
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
  endtask

  task automatic run_seq(input logic [31:0] base, input int mode);
    int budget, stalls_left, gap_left, start_cyc;
    bit l2_pulsed, fin_pulsed;
    acc_cnt = 0; valid_cnt = 0; done_cnt = 0; a100a_cycles = 0;
    stalls_left = 3; gap_left = 5; l2_pulsed = 0; fin_pulsed = 0;
    exp_q.delete();
    for (int i = 0; i < Total; i++) exp_q.push_back(ref_word(base, i));
    @(posedge clk); #1;
    base_addr = base; start = 1'b1; consumer_ready = 1'b1; avm_waitrequest = 1'b0;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 20000 && !(mode == MRst && acc_cnt >= 301)) begin
      consumer_ready = 1'b1; avm_waitrequest = 1'b0; start = 1'b0;
      case (mode)
        MRand: begin
          consumer_ready  = ($urandom_range(0, 4) != 0);
          avm_waitrequest = ($urandom_range(0, 3) == 0);
        end
        MStall: if (busy && avm_address == 32'h100A && stalls_left > 0) begin
          avm_waitrequest = 1'b1;
          stalls_left--;
        end
        MGap: if (acc_cnt == 128 && gap_left > 0) begin
          consumer_ready = 1'b0;
          gap_left--;
        end
        ML2Start: begin
          if (acc_cnt == 1100 && !l2_pulsed) begin start = 1'b1; l2_pulsed = 1; end
          if (acc_cnt == Total && !fin_pulsed) begin start = 1'b1; fin_pulsed = 1; end
        end
        default: ;
      endcase
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0; consumer_ready = 1'b1; avm_waitrequest = 1'b0;
    if (mode == MRst) begin
      check("rst_reached_word_300", {31'd0, acc_cnt >= 301}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs();
      rst = 1'b0;
      exp_q.delete();
      return;
    end
    check("done_seen", done_cnt, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("valid_count", valid_cnt, Total);
    check("queue_empty", exp_q.size(), 32'd0);
    check("single_done", done_cnt, 32'd1);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("first_addr", first_acc_addr, base);
    check("last_addr", last_acc_addr, base + 32'(Total - 1));
    if (mode == MDirect || mode == ML2Start) begin
      check("done_latency", done_cyc - start_cyc, 32'd1298);
      check("done_after_last_valid", done_cyc - last_valid_cyc, 32'd1);
    end
    if (mode == MStall) begin
      check("addr_100a_held", a100a_cycles, 32'd4);
      check("done_latency_stall", done_cyc - start_cyc, 32'd1301);
`ifdef SEQ_STALL_CNT_EN
      check("stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; consumer_ready = 1'b0; avm_waitrequest = 1'b0;
    base_addr = '0;
    acc_cnt = 0; valid_cnt = 0; done_cnt = 0; a100a_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    run_seq(32'h0000_1000, MDirect);
    run_seq(32'h0000_1000, MStall);
    run_seq(32'h0000_3000, MGap);
    run_seq(32'h0000_4000, ML2Start);
    run_seq(32'hFFFF_FE00, MRand);
    run_seq($urandom, MRand);
    run_seq(32'h0000_1000, MRst);
    run_seq(32'h0000_2000, MDirect);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
